// File: rtl/fx_pkg.sv
// ---------------------------------------------------------------------------
// fx_pkg
// Shared definitions for the fixed-point squarer (fx_square) and its
// combinational shift-add step (fx_shift_add_step).
//   FX_WIDTH    : default operand width (unsigned Q6.10 input)
//   FX_FRAC     : default operand fraction bits
//   FX_HALF_LSB : half of one Q6.10 LSB expressed in the Q12.20 product,
//                 i.e. the round-half-up bias for the optional Q6.10 output
//   fx_state_e  : squarer FSM state encoding
// ---------------------------------------------------------------------------
package fx_pkg;

  localparam int FX_WIDTH    = 16;
  localparam int FX_FRAC     = 10;
  localparam int FX_HALF_LSB = 1 << (FX_FRAC - 1);

  // IDLE -> CALC -> DONE -> HOLD -> IDLE; CALC/DONE abort back to IDLE
  // when the level request drops.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } fx_state_e;

endpackage : fx_pkg

// File: rtl/fx_shift_add_step.sv
// ---------------------------------------------------------------------------
// fx_shift_add_step
// One LSB-first shift-add multiplication step, purely combinational.
//   acc         in  : running partial product (2*WIDTH bits)
//   mcand       in  : multiplicand, already shifted for this step
//   mplier      in  : remaining multiplier bits; bit 0 selects the add
//   acc_next    out : acc + (mplier[0] ? mcand : 0)
//   mcand_next  out : mcand << 1
//   mplier_next out : mplier >> 1
// The accumulator is 2*WIDTH bits wide so the full product of two WIDTH-bit
// operands never overflows.
// ---------------------------------------------------------------------------
module fx_shift_add_step
  import fx_pkg::*;
#(
  parameter int WIDTH = FX_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplier_next
);

  assign acc_next    = mplier[0] ? (acc + mcand) : acc;
  assign mcand_next  = mcand << 1;
  assign mplier_next = mplier >> 1;

endmodule : fx_shift_add_step

// File: rtl/fx_square.sv
// ---------------------------------------------------------------------------
// fx_square
// Iterative fixed-point squarer. Takes an unsigned Q6.10 operand and returns
// its exact square as unsigned Q12.20, one shift-add step per clock.
//
// Handshake (shared with the sqrt block so a controller can use either):
//   enable is a level request. Seen high in IDLE, it starts an operation and
//   X is latched on that edge only. enable must stay high through CALC and
//   DONE; if it is seen low there the operation is abandoned with no done
//   pulse and Result unchanged. done pulses for exactly one cycle in the
//   cycle Result takes the new value. Afterwards the block waits in HOLD
//   until enable goes low, so each assertion of enable yields one result.
//
// Timing: start edge k, WIDTH CALC edges (k+1 .. k+WIDTH), Result/done
// registered at edge k+WIDTH+1.
//
// Ports
//   clk      in  : clock, all logic on posedge
//   rst_n    in  : synchronous active-low reset
//   enable   in  : level request
//   X        in  : operand, unsigned Q6.10 (WIDTH bits)
//   Result   out : X*X, unsigned Q12.20 (2*WIDTH bits), registered
//   done     out : one-cycle pulse when Result is updated
//   Result_q out : (only with FX_SQUARE_Q610_OUT_EN) Result rounded
//                  half-up back to Q6.10, saturated to all-ones
//
// Configuration macro: FX_SQUARE_Q610_OUT_EN enables the Result_q port and
// its rounding logic. Without it, Result/done behaviour is identical.
// ---------------------------------------------------------------------------
module fx_square
  import fx_pkg::*;
#(
  parameter int WIDTH = FX_WIDTH,
  parameter int FRAC  = FX_FRAC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [WIDTH-1:0]   X,
  output logic [2*WIDTH-1:0] Result,
`ifdef FX_SQUARE_Q610_OUT_EN
  output logic [WIDTH-1:0]   Result_q,
`endif
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  // Value of cnt during the final CALC step.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  // FSM state is kept in a plainly named register so checkers can bind to it.
  fx_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mcand_next;
  logic [WIDTH-1:0]   mplier_next;

  fx_shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc         (acc),
    .mcand       (mcand),
    .mplier      (mplier),
    .acc_next    (acc_next),
    .mcand_next  (mcand_next),
    .mplier_next (mplier_next)
  );

`ifdef FX_SQUARE_Q610_OUT_EN
  // Round-half-up from Q12.20 to Q6.10: add half an output LSB, drop FRAC
  // fraction bits, then clamp anything that no longer fits in WIDTH bits.
  // One extra bit on the sum keeps the carry of the bias addition.
  localparam logic [2*WIDTH:0] HALF_LSB = (2*WIDTH+1)'(1) << (FRAC - 1);
  localparam int RQ_W = 2*WIDTH + 1 - FRAC;

  logic [2*WIDTH:0] rounded_sum;
  logic [RQ_W-1:0]  rq_full;
  logic             rq_sat;
  logic [WIDTH-1:0] rq_val;

  always_comb begin
    rounded_sum = {1'b0, acc} + HALF_LSB;
    rq_full     = RQ_W'(rounded_sum >> FRAC);
    rq_sat      = |rq_full[RQ_W-1:WIDTH];
    rq_val      = rq_sat ? {WIDTH{1'b1}} : rq_full[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      Result <= '0;
      done   <= 1'b0;
`ifdef FX_SQUARE_Q610_OUT_EN
      Result_q <= '0;
`endif
    end else begin
      // done is a pulse: only the DONE branch raises it, for one cycle.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            mcand  <= {{WIDTH{1'b0}}, X};
            mplier <= X;
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end
        end

        CALC: begin
          if (!enable) begin
            // Abandoned: partial product is discarded, Result untouched.
            state <= IDLE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST_STEP) begin
              state <= DONE;
            end
          end
        end

        DONE: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            Result <= acc;
            done   <= 1'b1;
`ifdef FX_SQUARE_Q610_OUT_EN
            Result_q <= rq_val;
`endif
            state  <= HOLD;
          end
        end

        HOLD: begin
          // Wait for the request to drop so one assertion gives one result.
          if (!enable) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : fx_square

// File: tb/tb_fx_square.sv
// ---------------------------------------------------------------------------
// tb_fx_square
// Self-checking bench for fx_square. Driver tasks issue operations and push
// the expected square (and the cycle in which done must appear) into
// queues; an independent monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_fx_square;

  localparam int W   = 16;
  localparam int LAT = W + 2; // negedges from request set-up to done visible

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic [W-1:0]  x_in = '0;
  logic [2*W-1:0] result;
  logic          done;
`ifdef FX_SQUARE_Q610_OUT_EN
  logic [W-1:0]  result_q;
`endif

  fx_square dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .X        (x_in),
    .Result   (result),
`ifdef FX_SQUARE_Q610_OUT_EN
    .Result_q (result_q),
`endif
    .done     (done)
  );

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];
`ifdef FX_SQUARE_Q610_OUT_EN
  logic [W-1:0]   exp_rq_q[$];
`endif
  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int done_count = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] model_square(input logic [W-1:0] v);
    longint p;
    p = longint'(v) * longint'(v);
    return p[2*W-1:0];
  endfunction

  function automatic logic [W-1:0] model_round_q610(input logic [W-1:0] v);
    longint p;
    p = (longint'(v) * longint'(v) + 512) / 1024;
    if (p > 65535) p = 65535;
    return p[W-1:0];
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_count++;
      check("done_one_cycle", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        logic [2*W-1:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", result, e);
        check("latency", 32'(cyc), 32'(ec));
`ifdef FX_SQUARE_Q610_OUT_EN
        begin
          logic [W-1:0] er;
          er = exp_rq_q.pop_front();
          check("result_q", {16'd0, result_q}, {16'd0, er});
        end
`endif
      end
    end
    prev_done = done;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full operation: enable held for hold_cyc negedges (>= LAT), then low.
  task automatic run_op(input logic [W-1:0] v, input int hold_cyc, input int gap);
    @(negedge clk);
    x_in   = v;
    enable = 1'b1;
    exp_q.push_back(model_square(v));
    exp_cyc_q.push_back(cyc + LAT);
`ifdef FX_SQUARE_Q610_OUT_EN
    exp_rq_q.push_back(model_round_q610(v));
`endif
    // X wiggles after the start edge must not matter.
    @(negedge clk);
    x_in = W'($urandom);
    repeat (hold_cyc - 1) @(negedge clk);
    enable = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Operation that will be interrupted: nothing is expected from it.
  task automatic start_no_push(input logic [W-1:0] v);
    @(negedge clk);
    x_in   = v;
    enable = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dc;
    logic [W-1:0] fixed_x[6];
    fixed_x = '{16'h0400, 16'h0C00, 16'h0200, 16'h0000, 16'hFFFF, 16'h0600};

    do_reset();
    @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_done", {31'd0, done}, 32'd0);

    // Directed values.
    foreach (fixed_x[i]) run_op(fixed_x[i], LAT, 1);

    // Abort during CALC after 5 steps.
    run_op(16'h0400, LAT, 1);
    dc = done_count;
    start_no_push(16'h0C00);
    repeat (6) @(negedge clk);
    enable = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_result_kept", result, 32'h0010_0000);
    check("abort_no_done", 32'(done_count - dc), 32'd0);
    run_op(16'h0C00, LAT, 1);

    // Enable held long: exactly one done.
    dc = done_count;
    run_op(16'h0600, 40, 2);
    check("hold_one_done", 32'(done_count - dc), 32'd1);

    // Reset in the middle of CALC.
    start_no_push(16'h0A00);
    repeat (8) @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("midreset_result", result, 32'h0);
    check("midreset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_no_done", {31'd0, done}, 32'd0);
    run_op(16'h0A00, LAT, 1);

    // Randomized operations with random hold length and idle gap.
    for (int n = 0; n < 25; n++) begin
      run_op(W'($urandom_range(0, 16'hFFFF)), $urandom_range(LAT, LAT + 6),
             $urandom_range(1, 3));
    end

    repeat (30) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_fx_square
